// File: rtl/alu_unit_if.sv
//------------------------------------------------------------------------------
// alu_unit_if : operand/function/result bundle for the alu_unit bit-slice ALU.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_unit_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       S;
  logic             M;
  logic             Cin;
  logic             en;
  logic [WIDTH-1:0] D;
  logic             Cout;
  logic [WIDTH-1:0] D_r;
  logic             Cout_r;
  logic             valid_r;

  modport master (
    output A, B, S, M, Cin, en,
    input  D, Cout, D_r, Cout_r, valid_r
  );

  modport slave (
    input  A, B, S, M, Cin, en,
    output D, Cout, D_r, Cout_r, valid_r
  );
endinterface

`default_nettype wire

// File: rtl/alu_unit.sv
//------------------------------------------------------------------------------
// alu_unit : 74181-style 16-function ALU with ripple carry chain and an
//            optional registered copy of the result and carry.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_unit #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_ONES = '1;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] logic_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] r_d;
  logic             r_cout;
  logic             r_valid;

  // Arithmetic mode: every function is expressed as X plus Y plus Cin.
  always_comb begin
    x = '0;
    y = '0;
    case (bus.S)
      4'd0:    begin x = bus.A;            y = '0;               end
      4'd1:    begin x = bus.A | bus.B;    y = '0;               end
      4'd2:    begin x = bus.A | ~bus.B;   y = '0;               end
      4'd3:    begin x = '0;               y = C_ONES;           end
      4'd4:    begin x = bus.A;            y = bus.A & ~bus.B;   end
      4'd5:    begin x = bus.A | bus.B;    y = bus.A & ~bus.B;   end
      4'd6:    begin x = bus.A;            y = ~bus.B;           end
      4'd7:    begin x = bus.A & ~bus.B;   y = C_ONES;           end
      4'd8:    begin x = bus.A;            y = bus.A & bus.B;    end
      4'd9:    begin x = bus.A;            y = bus.B;            end
      4'd10:   begin x = bus.A | ~bus.B;   y = bus.A & bus.B;    end
      4'd11:   begin x = bus.A & bus.B;    y = C_ONES;           end
      4'd12:   begin x = bus.A;            y = bus.A;            end
      4'd13:   begin x = bus.A | bus.B;    y = bus.A;            end
      4'd14:   begin x = bus.A | ~bus.B;   y = bus.A;            end
      default: begin x = bus.A;            y = C_ONES;           end
    endcase
  end

  always_comb begin
    logic_d = '0;
    case (bus.S)
      4'd0:    logic_d = ~bus.A;
      4'd1:    logic_d = ~(bus.A | bus.B);
      4'd2:    logic_d = ~bus.A & bus.B;
      4'd3:    logic_d = '0;
      4'd4:    logic_d = ~(bus.A & bus.B);
      4'd5:    logic_d = ~bus.B;
      4'd6:    logic_d = bus.A ^ bus.B;
      4'd7:    logic_d = bus.A & ~bus.B;
      4'd8:    logic_d = ~bus.A | bus.B;
      4'd9:    logic_d = ~(bus.A ^ bus.B);
      4'd10:   logic_d = bus.B;
      4'd11:   logic_d = bus.A & bus.B;
      4'd12:   logic_d = C_ONES;
      4'd13:   logic_d = bus.A | ~bus.B;
      4'd14:   logic_d = bus.A | bus.B;
      default: logic_d = bus.A;
    endcase
  end

  assign carry[0] = bus.Cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]     = x[i] ^ y[i] ^ carry[i];
      assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end
  endgenerate

  assign bus.D    = bus.M ? sum : logic_d;
  assign bus.Cout = bus.M & carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.en;
      if (bus.en) begin
        r_d    <= bus.D;
        r_cout <= bus.Cout;
      end
    end
  end

  assign bus.D_r     = r_d;
  assign bus.Cout_r  = r_cout;
  assign bus.valid_r = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
//------------------------------------------------------------------------------
// tb_alu_unit : scoreboard bench for alu_unit at WIDTH=1 and WIDTH=32.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_unit_if #(.WIDTH(1))  b1 ();
  alu_unit_if #(.WIDTH(32)) b32 ();

  alu_unit #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  alu_unit #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [32:0] got);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // Reference: arithmetic as a plain integer add, logic as a truth table.
  function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s, input logic m, input logic cin);
    logic [31:0] mask, xv, yv, lv, ones;
    logic [32:0] full;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ones = mask;
    a = a & mask;
    b = b & mask;
    case (s)
      4'd0:  begin xv = a;      yv = 0;      lv = ~a;      end
      4'd1:  begin xv = a | b;  yv = 0;      lv = ~(a | b); end
      4'd2:  begin xv = a | ~b; yv = 0;      lv = ~a & b;  end
      4'd3:  begin xv = 0;      yv = ones;   lv = 0;       end
      4'd4:  begin xv = a;      yv = a & ~b; lv = ~(a & b); end
      4'd5:  begin xv = a | b;  yv = a & ~b; lv = ~b;      end
      4'd6:  begin xv = a;      yv = ~b;     lv = a ^ b;   end
      4'd7:  begin xv = a & ~b; yv = ones;   lv = a & ~b;  end
      4'd8:  begin xv = a;      yv = a & b;  lv = ~a | b;  end
      4'd9:  begin xv = a;      yv = b;      lv = ~(a ^ b); end
      4'd10: begin xv = a | ~b; yv = a & b;  lv = b;       end
      4'd11: begin xv = a & b;  yv = ones;   lv = a & b;   end
      4'd12: begin xv = a;      yv = a;      lv = ones;    end
      4'd13: begin xv = a | b;  yv = a;      lv = a | ~b;  end
      4'd14: begin xv = a | ~b; yv = a;      lv = a | b;   end
      default: begin xv = a;    yv = ones;   lv = a;       end
    endcase
    xv = xv & mask;
    yv = yv & mask;
    if (m) begin
      full = {1'b0, xv} + {1'b0, yv} + {32'd0, cin};
      return {full[w], full[31:0] & mask};
    end
    return {1'b0, lv & mask};
  endfunction

  function automatic logic [32:0] obs1();
    return {b1.Cout, 31'd0, b1.D};
  endfunction

  function automatic logic [32:0] obs32();
    return {b32.Cout, b32.D};
  endfunction

  function automatic logic [32:0] obs1_reg();
    return {b1.valid_r, b1.Cout_r, 30'd0, b1.D_r};
  endfunction

  task automatic drive1(input logic a, input logic b, input logic [3:0] s, input logic m, input logic cin);
    b1.A = a; b1.B = b; b1.S = s; b1.M = m; b1.Cin = cin;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                         input logic m, input logic cin);
    b32.A = a; b32.B = b; b32.S = s; b32.M = m; b32.Cin = cin;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic        cin;
    logic [32:0] exp;
  } vec_t;

  vec_t dir[6];
  logic [15:0] logic_lut;
  logic [31:0] ra, rb;
  logic [3:0]  rs;
  logic        rm, rc;

  initial begin
    dir[0] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd9, 1'b0, {1'b0, 32'hFFFF_FFFE}};
    dir[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd6, 1'b1, {1'b1, 32'h0000_0000}};
    dir[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 1'b0, {1'b1, 32'hFFFF_FFFE}};
    dir[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 1'b1, {1'b1, 32'h0000_0000}};
    dir[4] = '{32'h000F_FFFF, 32'h000F_FFFF, 4'd9, 1'b0, {1'b0, 32'h001F_FFFE}};
    dir[5] = '{32'h000F_FFFF, 32'h000F_FFFF, 4'd6, 1'b1, {1'b1, 32'h0000_0000}};
    logic_lut = 16'hF0F0;

    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive32(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    b1.en = 1'b0;
    b32.en = 1'b0;

    #2;
    check("rst_reg1", obs1_reg(), 33'd0);
    check("rst_reg32", {b32.Cout_r, b32.D_r}, 33'd0);
    check("rst_valid32", {32'd0, b32.valid_r}, 33'd0);

    // Loads requested while reset is held must not take effect.
    b1.en = 1'b1;
    drive1(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("rst_over_en", obs1_reg(), 33'd0);
    b1.en = 1'b0;

    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      drive1(1'b1, 1'b0, s[3:0], 1'b0, 1'b1);
      exp_q.push_back({1'b0, 31'd0, logic_lut[s]});
      #1 pop_check($sformatf("logic1_s%0d", s), obs1());
    end

    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        drive1(k[0], k[1], s[3:0], 1'b1, k[2]);
        exp_q.push_back(model(1, {31'd0, k[0]}, {31'd0, k[1]}, s[3:0], 1'b1, k[2]));
        #1 pop_check($sformatf("arith1_s%0d_k%0d", s, k), obs1());
      end
    end

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive32(dir[i].a, dir[i].b, dir[i].s, 1'b1, dir[i].cin);
      exp_q.push_back(dir[i].exp);
      #1 pop_check($sformatf("dir32_%0d", i), obs32());
    end

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ra = $urandom; rb = $urandom;
      rs = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (i < 4) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; end
      drive32(ra, rb, rs, rm, rc);
      exp_q.push_back(model(32, ra, rb, rs, rm, rc));
      #1 pop_check($sformatf("rnd32_%0d", i), obs32());
    end

    // Register stage: release reset, load, hold, then clear asynchronously.
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
    b1.en = 1'b1;
    drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 1'b1, 1'b0);
    b32.en = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 31'd0});
    exp_q.push_back({1'b1, 32'hFFFF_FFFE});
    @(posedge clk); #1;
    pop_check("load1", obs1_reg());
    pop_check("load32", {b32.Cout_r, b32.D_r});
    check("load32_valid", {32'd0, b32.valid_r}, 33'd1);

    @(negedge clk);
    b1.en = 1'b0;
    b32.en = 1'b0;
    drive1(1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
    drive32(32'd1, 32'd2, 4'd9, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 31'd0});
    exp_q.push_back({1'b1, 32'hFFFF_FFFE});
    @(posedge clk); #1;
    pop_check("hold1", obs1_reg());
    pop_check("hold32", {b32.Cout_r, b32.D_r});
    check("hold32_valid", {32'd0, b32.valid_r}, 33'd0);
    check("hold_comb1", obs1(), {1'b0, 31'd0, 1'b1});

    #2 rst_n = 1'b0;
    #1;
    check("async_clr1", obs1_reg(), 33'd0);
    check("async_clr32", {b32.Cout_r, b32.D_r}, 33'd0);
    check("comb_in_rst", obs32(), {1'b0, 32'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
